// File: rtl/pu_ex_muldiv_hlr.sv
// rtl/pu_ex_muldiv_hlr.sv - HI/LO registers with iterative radix-2 multiply/divide engine
// Optional: define PU_MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module pu_ex_muldiv_hlr #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi_rd_data,
  output logic [DATA_W-1:0] lo_rd_data
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] acc_q;    // product high half / partial remainder
  logic [DATA_W-1:0] mreg_q;   // multiplier (shifts out) / dividend->quotient
  logic [DATA_W-1:0] opnd_q;   // multiplicand or divisor magnitude
  logic [DATA_W-1:0] raw_a_q;  // dividend as issued, for divide-by-zero HI
  logic [CNT_W-1:0]  cnt_q;
  logic              is_div_q, neg_q_q, neg_r_q, dz_q;
  logic              busy_q, done_q;

  // Operand magnitudes and result signs for the op being issued
  logic              signed_op, sa, sb;
  logic [DATA_W-1:0] a_mag, b_mag;
  always_comb begin
    signed_op = (op == 3'd0) || (op == 3'd2);
    sa        = signed_op & src_a[DATA_W-1];
    sb        = signed_op & src_b[DATA_W-1];
    a_mag     = sa ? -src_a : src_a;
    b_mag     = sb ? -src_b : src_b;
  end

  // One shift-add multiply step and one restoring shift-subtract divide step
  logic [DATA_W:0]   mul_sum, div_shift;
  logic [DATA_W-1:0] mul_acc_d, mul_mreg_d, div_acc_d, div_mreg_d, div_diff;
  logic              div_ge;
  always_comb begin
    mul_sum    = {1'b0, acc_q} + (mreg_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc_d  = mul_sum[DATA_W:1];
    mul_mreg_d = {mul_sum[0], mreg_q[DATA_W-1:1]};
    div_shift  = {acc_q, mreg_q[DATA_W-1]};
    div_ge     = div_shift >= {1'b0, opnd_q};
    // When div_ge holds, the true difference is below the divisor, so W bits suffice
    div_diff   = div_shift[DATA_W-1:0] - opnd_q;
    div_acc_d  = div_ge ? div_diff : div_shift[DATA_W-1:0];
    div_mreg_d = {mreg_q[DATA_W-2:0], div_ge};
  end

  // Sign correction and final HI/LO values written at the FIX edge
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   hi_d, lo_d;
  always_comb begin
`ifdef PU_MULDIV_FAST_MUL_EN
    prod = {{DATA_W{1'b0}}, opnd_q} * {{DATA_W{1'b0}}, mreg_q};
`else
    prod = {acc_q, mreg_q};
`endif
    prod_fix = neg_q_q ? -prod : prod;
    if (!is_div_q) begin
      hi_d = prod_fix[2*DATA_W-1:DATA_W];
      lo_d = prod_fix[DATA_W-1:0];
    end else if (dz_q) begin
      hi_d = raw_a_q;
      lo_d = '1;
    end else begin
      hi_d = neg_r_q ? -acc_q : acc_q;
      lo_d = neg_q_q ? -mreg_q : mreg_q;
    end
  end

  // Control FSM with registered busy/done, datapath and HI/LO updates
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      mreg_q   <= '0;
      opnd_q   <= '0;
      raw_a_q  <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start && !flush) begin
            if (op == 3'd4) hi_q <= src_a;
            if (op == 3'd5) lo_q <= src_a;
            if (!op[2]) begin
              is_div_q <= op[1];
              neg_q_q  <= sa ^ sb;
              neg_r_q  <= sa;
              dz_q     <= op[1] && (src_b == '0);
              raw_a_q  <= src_a;
              acc_q    <= '0;
              mreg_q   <= op[1] ? a_mag : b_mag;
              opnd_q   <= op[1] ? b_mag : a_mag;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
`ifdef PU_MULDIV_FAST_MUL_EN
              state_q  <= op[1] ? CALC : FIX;
              done_q   <= !op[1];
`else
              state_q  <= CALC;
`endif
            end
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            acc_q  <= is_div_q ? div_acc_d : mul_acc_d;
            mreg_q <= is_div_q ? div_mreg_d : mul_mreg_d;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W-1)) begin
              state_q <= FIX;
              done_q  <= 1'b1;
            end
          end
        end
        FIX: begin
          if (!flush) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
          end
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign hi_rd_data = hi_q;
  assign lo_rd_data = lo_q;

endmodule
